// File: rtl/id_exe_reg_pkg.sv
// id_exe_reg_pkg: shared ALU opcodes and the EXE stage payload type
package id_exe_reg_pkg;
  localparam logic [3:0] ALU_OPC_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OPC_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OPC_AND  = 4'b0010;
  localparam logic [3:0] ALU_OPC_OR   = 4'b0011;
  localparam logic [3:0] ALU_OPC_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OPC_SLT  = 4'b0101;
  localparam logic [3:0] ALU_OPC_SLTU = 4'b0110;
  localparam logic [3:0] ALU_OPC_SLL  = 4'b0111;
  localparam logic [3:0] ALU_OPC_SRL  = 4'b1000;
  localparam logic [3:0] ALU_OPC_EQ   = 4'b1001;
  localparam logic [3:0] ALU_OPC_NE   = 4'b1010;
  localparam logic [3:0] ALU_OPC_GE   = 4'b1011;
  localparam logic [3:0] ALU_OPC_GEU  = 4'b1100;
  localparam logic [3:0] ALU_OPC_SRA  = 4'b1101;
  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_opc;
    logic        sel_pc;
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] src2;
    logic [4:0]  rd;
    logic        wen;
    logic        is_load;
  } exe_t;
endpackage

// File: rtl/id_exe_reg_fwd_mux.sv
// fwd_mux: picks the freshest value of one source register (EXE > MEM > regfile)
module fwd_mux (
  input  logic [4:0]  rs,
  input  logic [31:0] rs_data,
  input  logic        exe_valid,
  input  logic        exe_wen,
  input  logic        exe_is_load,
  input  logic [4:0]  exe_rd,
  input  logic [31:0] alu_result,
  input  logic        mem_valid,
  input  logic        mem_wen,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_wdata,
  output logic [31:0] value
);
  logic exe_hit, mem_hit;
  always_comb begin
    exe_hit = (rs != 5'd0) && exe_valid && exe_wen && !exe_is_load && (exe_rd == rs);
    mem_hit = (rs != 5'd0) && mem_valid && mem_wen && (mem_rd == rs);
    value = exe_hit ? alu_result : mem_hit ? mem_wdata : rs_data;
  end
endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: decode-to-execute pipeline register with operand forwarding and load-use stall
module id_exe_reg
  import id_exe_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [3:0]  dec_alu_opc,
  input  logic        dec_sel_pc,
  input  logic [31:0] dec_pc,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic [31:0] dec_rs1_data,
  input  logic [31:0] dec_rs2_data,
  input  logic [31:0] dec_imm,
  input  logic        dec_sel_imm,
  input  logic [4:0]  dec_rd,
  input  logic        dec_wen,
  input  logic        dec_is_load,
  input  logic [31:0] alu_result,
  input  logic        mem_valid,
  input  logic        mem_wen,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_wdata,
  input  logic        hold,
  input  logic        flush,
  output logic        exe_valid_r,
  output logic [3:0]  exe_alu_opc_r,
  output logic        exe_sel_pc_r,
  output logic [31:0] exe_pc_r,
  output logic [31:0] exe_reg1_r,
  output logic [31:0] exe_src2_r,
  output logic [4:0]  exe_rd_r,
  output logic        exe_wen_r,
  output logic        exe_is_load_r,
  output logic        dec_stall
);
  exe_t q, d, nxt;
  logic [31:0] fwd1, fwd2;
  logic load_use;
  fwd_mux u_fwd1 (
    .rs(dec_rs1), .rs_data(dec_rs1_data),
    .exe_valid(q.valid), .exe_wen(q.wen), .exe_is_load(q.is_load), .exe_rd(q.rd),
    .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
    .value(fwd1)
  );
  fwd_mux u_fwd2 (
    .rs(dec_rs2), .rs_data(dec_rs2_data),
    .exe_valid(q.valid), .exe_wen(q.wen), .exe_is_load(q.is_load), .exe_rd(q.rd),
    .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
    .value(fwd2)
  );
  // a bubble is the all-zero payload, which also encodes ALU_OPC_ADD with no writeback
  always_comb begin
    load_use = dec_valid && q.valid && q.is_load && (q.rd != 5'd0) &&
               ((dec_use_rs1 && dec_rs1 == q.rd) || (dec_use_rs2 && dec_rs2 == q.rd));
    dec_stall = hold || load_use;
    d = '{valid: 1'b1, alu_opc: dec_alu_opc, sel_pc: dec_sel_pc, pc: dec_pc,
          reg1: fwd1, src2: dec_sel_imm ? dec_imm : fwd2,
          rd: dec_rd, wen: dec_wen, is_load: dec_is_load};
    nxt = flush ? '0 : hold ? q : (load_use || !dec_valid) ? '0 : d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= nxt;
  assign exe_valid_r   = q.valid;
  assign exe_alu_opc_r = q.alu_opc;
  assign exe_sel_pc_r  = q.sel_pc;
  assign exe_pc_r      = q.pc;
  assign exe_reg1_r    = q.reg1;
  assign exe_src2_r    = q.src2;
  assign exe_rd_r      = q.rd;
  assign exe_wen_r     = q.wen;
  assign exe_is_load_r = q.is_load;
endmodule
